flb_sync_strobe_gen: RTL
========================

// Module: flb_sync_strobe_gen
// PURPOSE
// - Next-generation FLB sync: moves ref_clk timing into the nsh_clk domain and samples DLF/band words once per ref period.
// - Replaces derived clocks with single-cycle enable strobes (smpl_stb, dec_stb); every flop runs on nsh_clk.
// - Generalised: sync depth, lag range and data widths are parameters. Adds lag shadowing, ref period measurement and a ref-loss watchdog.
// PARAMETERS
// - SYNC_STAGES  2    ref_clk synchroniser flops, >=2.
// - LAG_W        3    lag CSR width; lags 0..2**LAG_W-1.
// - OS_W         8    s_os width = dlf_out LSB slice.
// - MTRX_W       8    s_mtrx width = dlf_out MSB slice.
// - BAND_W       8    band / s_band width.
// - CNT_W        10   period / watchdog counter width.
// PORTS
// - nsh_clk               in   1               sole clock.
// - csr_sync_en           in   1               async active-low reset; low clears all state.
// - ref_clk               in   1               asynchronous reference clock.
// - dlf_out               in   OS_W+MTRX_W     loop-filter word; quasi-static across smpl_stb.
// - band                  in   BAND_W          band code.
// - csr_flb_smpl_clk_lag  in   LAG_W           extra cycles from detected edge to smpl_stb.
// - csr_flb_mtrx_clk_lag  in   LAG_W           extra cycles from detected edge to dec_stb.
// - csr_flb_sdm_thrm_en   in   1               1: dec_stb is lagged pulse; 0: dec_stb tied 1.
// - csr_wd_limit          in   CNT_W           nsh cycles without edge before ref_lost; 0 disables.
// - csr_lost_clr          in   1               one-cycle pulse; clears sticky ref_lost.
// - s_os / s_mtrx / s_band out OS_W/MTRX_W/BAND_W  sampled words.
// - smpl_stb              out  1               one cycle; sample load cycle.
// - dec_stb               out  1               matrix/decoder enable.
// - ref_period            out  CNT_W           nsh cycles between last two ref rising edges.
// - ref_lost              out  1               sticky watchdog flag.
// BEHAVIOUR
// - Reset: all outputs 0. dec_stb is 1 only once csr_sync_en is high and thrm_en=0. Shadow lags 0, counters 0.
// - Sync: SYNC_STAGES flops on ref_clk, then one extra flop. edge = sync_last & ~extra; high exactly 1 cycle per ref rising edge.
// - Pulse pipe: p[0]=edge; p[k]=p[k-1] delayed one cycle, k=1..2**LAG_W+1.
// - Shadow lags: smpl_lag_q / mtrx_lag_q load from CSRs only in cycles where edge=1. A mid-period CSR change
//   takes effect from the next edge; no dropped or doubled strobe.
// - smpl_stb = p[1+smpl_lag_q]. dec_stb = thrm_en ? p[2+mtrx_lag_q] : 1'b1 (combinational select of registered pulses).
// - Sample: on clock edge with smpl_stb=1, s_os<=dlf_out[OS_W-1:0], s_mtrx<=dlf_out[OS_W+:MTRX_W], s_band<=band;
//   new values visible next cycle; otherwise hold.
// - Latency, lag L: ref rise to smpl_stb = SYNC_STAGES+2+L nsh cycles (+/-1 sync uncertainty).
// - Period counter: cnt increments each cycle, saturates at 2**CNT_W-1. On edge: ref_period<=cnt+1 (saturating), cnt<=0.
//   ref_period=0 until the second edge after reset.
// - Watchdog: if csr_wd_limit!=0 and cnt+1 >= csr_wd_limit with no edge -> ref_lost<=1 (sticky).
//   csr_lost_clr clears it; if clear and set condition coincide, set wins.
// - Ref loss: strobes stop, samples hold last value; recovery needs no reset.
// - Edge shorter than pipe depth: back-to-back edges are legal; each produces its own strobe, pipe bits independent.
// - csr_sync_en low mid-operation: immediate clear, in-flight pulses discarded; first edge after release needs full latency.
// STRUCTURE
// - flb_sync_pkg: SYNC_STAGES/LAG_W/CNT_W defaults, pulse-pipe depth function PIPE_D(LAG_W)=2**LAG_W+2.
// - Sub-module flb_sync_edge_det: synchroniser chain + edge detect (params SYNC_STAGES; ports nsh_clk, csr_sync_en, ref_clk, edge).
// - Top: shadow lags, pulse pipe, strobe muxes, sample registers, period/watchdog counter.
// TESTING
// - ref period 16 nsh, lag 0/0, thrm_en=1 -> smpl_stb every 16 cycles, dec_stb 1 cycle after smpl_stb, ref_period=16.
// - dlf_out=16'hA55A, band=8'h3C, lag smpl=5 -> s_os=8'h5A, s_mtrx=8'hA5, s_band=8'h3C one cycle after smpl_stb, 5 cycles later than lag 0.
// - thrm_en=0 -> dec_stb constant 1 after reset release; smpl_stb still periodic.
// - Change smpl lag 0->7 mid-period -> current period strobe at lag 0, next at lag 7, exactly one strobe per period.
// - csr_wd_limit=40, stop ref_clk -> ref_lost=1 at 40 cycles after last edge, samples frozen; restart + csr_lost_clr -> ref_lost=0, strobes resume.
// - Drop csr_sync_en for 1 cycle while pulses in flight -> all outputs 0, no strobe until next ref edge.

Source files
------------

// File: rtl/flb_sync_pkg.sv
// Shared defaults and helpers for the FLB sync / strobe generator.
package flb_sync_pkg;

  localparam int unsigned SyncStagesDef = 2;
  localparam int unsigned LagWDef       = 3;
  localparam int unsigned OsWDef        = 8;
  localparam int unsigned MtrxWDef      = 8;
  localparam int unsigned BandWDef      = 8;
  localparam int unsigned CntWDef       = 10;

  // Pulse pipe depth: p[0] is the raw edge, p[1..2**lag_w+1] are registered taps.
  function automatic int unsigned pipe_d(input int unsigned lag_w);
    return (32'd1 << lag_w) + 32'd2;
  endfunction

endpackage

// File: rtl/flb_sync_edge_det.sv
// Brings ref_clk into the nsh_clk domain and flags each rising edge for one cycle.
module flb_sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic nsh_clk,
  input  logic csr_sync_en,
  input  logic ref_clk,
  output logic ref_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   extra_q;

  // Synchroniser chain plus one history flop for edge detection.
  always_ff @(posedge nsh_clk or negedge csr_sync_en) begin
    if (!csr_sync_en) begin
      sync_q  <= '0;
      extra_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ref_clk};
      extra_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign ref_edge = sync_q[SYNC_STAGES-1] & ~extra_q;

endmodule

// File: rtl/flb_sync_strobe_gen.sv
// FLB sync: turns synchronised ref_clk edges into lagged sample/decoder strobes,
// samples DLF/band words, measures the ref period and watches for ref loss.
module flb_sync_strobe_gen
  import flb_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SyncStagesDef,
  parameter int unsigned LAG_W       = LagWDef,
  parameter int unsigned OS_W        = OsWDef,
  parameter int unsigned MTRX_W      = MtrxWDef,
  parameter int unsigned BAND_W      = BandWDef,
  parameter int unsigned CNT_W       = CntWDef
) (
  input  logic                   nsh_clk,
  input  logic                   csr_sync_en,
  input  logic                   ref_clk,
  input  logic [OS_W+MTRX_W-1:0] dlf_out,
  input  logic [BAND_W-1:0]      band,
  input  logic [LAG_W-1:0]       csr_flb_smpl_clk_lag,
  input  logic [LAG_W-1:0]       csr_flb_mtrx_clk_lag,
  input  logic                   csr_flb_sdm_thrm_en,
  input  logic [CNT_W-1:0]       csr_wd_limit,
  input  logic                   csr_lost_clr,
  output logic [OS_W-1:0]        s_os,
  output logic [MTRX_W-1:0]      s_mtrx,
  output logic [BAND_W-1:0]      s_band,
  output logic                   smpl_stb,
  output logic                   dec_stb,
  output logic [CNT_W-1:0]       ref_period,
  output logic                   ref_lost
);

  localparam int unsigned PipeD = pipe_d(LAG_W);
  // Registered taps only; pipe_q[k-1] holds p[k].
  localparam int unsigned PipeW = PipeD - 1;

  logic              ref_edge;
  logic [PipeW-1:0]  pipe_q;
  logic [LAG_W-1:0]  smpl_lag_q, mtrx_lag_q;
  logic              en_q;
  logic [LAG_W:0]    smpl_idx, dec_idx;
  logic [OS_W-1:0]   s_os_q;
  logic [MTRX_W-1:0] s_mtrx_q;
  logic [BAND_W-1:0] s_band_q;
  logic [CNT_W-1:0]  cnt_q, cnt_inc, period_q;
  logic              seen_q, lost_q, wd_hit;

  flb_sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_det (
    .nsh_clk    (nsh_clk),
    .csr_sync_en(csr_sync_en),
    .ref_clk    (ref_clk),
    .ref_edge   (ref_edge)
  );

  // Pulse pipe, lag shadows (latched only on an edge) and the release flag for dec_stb.
  always_ff @(posedge nsh_clk or negedge csr_sync_en) begin
    if (!csr_sync_en) begin
      pipe_q     <= '0;
      smpl_lag_q <= '0;
      mtrx_lag_q <= '0;
      en_q       <= 1'b0;
    end else begin
      pipe_q <= {pipe_q[PipeW-2:0], ref_edge};
      en_q   <= 1'b1;
      if (ref_edge) begin
        smpl_lag_q <= csr_flb_smpl_clk_lag;
        mtrx_lag_q <= csr_flb_mtrx_clk_lag;
      end
    end
  end

  // smpl_stb = p[1+lag] -> pipe_q[lag]; dec_stb = p[2+lag] -> pipe_q[1+lag].
  assign smpl_idx = {1'b0, smpl_lag_q};
  assign dec_idx  = {1'b0, mtrx_lag_q} + {{LAG_W{1'b0}}, 1'b1};
  assign smpl_stb = pipe_q[smpl_idx];
  assign dec_stb  = csr_flb_sdm_thrm_en ? pipe_q[dec_idx] : en_q;

  // Sample registers load on the strobe cycle and hold otherwise.
  always_ff @(posedge nsh_clk or negedge csr_sync_en) begin
    if (!csr_sync_en) begin
      s_os_q   <= '0;
      s_mtrx_q <= '0;
      s_band_q <= '0;
    end else if (smpl_stb) begin
      s_os_q   <= dlf_out[OS_W-1:0];
      s_mtrx_q <= dlf_out[OS_W +: MTRX_W];
      s_band_q <= band;
    end
  end

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign wd_hit  = (csr_wd_limit != '0) && (cnt_inc >= csr_wd_limit) && !ref_edge;

  // Period counter, period capture (from the second edge on) and sticky watchdog.
  always_ff @(posedge nsh_clk or negedge csr_sync_en) begin
    if (!csr_sync_en) begin
      cnt_q    <= '0;
      period_q <= '0;
      seen_q   <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      if (ref_edge) begin
        cnt_q  <= '0;
        seen_q <= 1'b1;
        if (seen_q) begin
          period_q <= cnt_inc;
        end
      end else begin
        cnt_q <= cnt_inc;
      end
      if (wd_hit) begin
        lost_q <= 1'b1;
      end else if (csr_lost_clr) begin
        lost_q <= 1'b0;
      end
    end
  end

  assign s_os       = s_os_q;
  assign s_mtrx     = s_mtrx_q;
  assign s_band     = s_band_q;
  assign ref_period = period_q;
  assign ref_lost   = lost_q;

endmodule
